// File: rtl/mem_stream_reader_pkg.sv
// Shared types and default widths for the mem_stream_reader block.
package mem_stream_reader_pkg;

   localparam int unsigned ADDR_W_DEFAULT     = 16;
   localparam int unsigned DATA_W_DEFAULT     = 18;
   localparam int unsigned DIM_W_DEFAULT      = 10;
   localparam int unsigned FIFO_DEPTH_DEFAULT = 2;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } state_e;

   typedef struct packed {
      logic eol;
      logic eof;
   } tag_t;

endpackage

// File: rtl/mem_stream_reader_fifo.sv
// Skid FIFO holding {data, eol, eof} words between the memory read port and the output stream.
module mem_stream_reader_fifo
   import mem_stream_reader_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEFAULT,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  tag_t              i_tag,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output tag_t              o_tag,
   output logic              o_empty,
   output logic [CNT_W-1:0]  o_count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] r_data [FIFO_DEPTH];
   tag_t              r_tag  [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   always_ff @(posedge clk) begin
      if (i_push) begin
         r_data[r_wr_ptr] <= i_data;
         r_tag[r_wr_ptr]  <= i_tag;
      end
   end

   // Power-of-two depth lets the pointers wrap on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_data[r_rd_ptr];
   assign o_tag   = r_tag[r_rd_ptr];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/mem_stream_reader.sv
// Raster-order region reader: drives a 1-cycle-latency memory read port into a valid/ready stream.
// Optional zero-padded border selected by defining MEM_STREAM_READER_PAD_EN.
module mem_stream_reader
   import mem_stream_reader_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
   parameter int unsigned DATA_W     = DATA_W_DEFAULT,
   parameter int unsigned DIM_W      = DIM_W_DEFAULT,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [ADDR_W-1:0] i_row_stride,
   input  logic [DIM_W-1:0]  i_width,
   input  logic [DIM_W-1:0]  i_height,
`ifdef MEM_STREAM_READER_PAD_EN
   input  logic              i_pad,
`endif
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W-1:0] o_mem_read_addr,
   input  logic [DATA_W-1:0] i_mem_read_data,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic              o_out_eol,
   output logic              o_out_eof
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned POS_W = DIM_W + 1;

   state_e            r_state;
   logic [ADDR_W-1:0] r_row_base;
   logic [ADDR_W-1:0] r_stride;
   logic [ADDR_W-1:0] r_last_addr;
   logic [POS_W-1:0]  r_col;
   logic [POS_W-1:0]  r_row;
   logic [POS_W-1:0]  r_last_col;
   logic [POS_W-1:0]  r_last_row;
   logic              r_inflight;
   logic              r_inflight_zero;
   tag_t              r_inflight_tag;
   logic              r_done;

   logic              w_border;
   logic [ADDR_W-1:0] w_first_row_base;
   logic [POS_W-1:0]  w_last_col;
   logic [POS_W-1:0]  w_last_row;
   logic              w_zero_size;
   logic              w_pop;
   logic              w_issue;
   logic              w_read;
   logic [ADDR_W-1:0] w_addr;
   tag_t              w_tag;
   tag_t              w_head_tag;
   logic              w_fifo_empty;
   logic [CNT_W-1:0]  w_count;
   logic [CNT_W:0]    w_used;
   logic [CNT_W:0]    w_limit;
   logic [DATA_W-1:0] w_push_data;

`ifdef MEM_STREAM_READER_PAD_EN
   logic r_pad;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pad <= 1'b0;
      end else if (r_state == StIdle && i_start) begin
         r_pad <= i_pad;
      end
   end

   // Row base starts one stride and one column early so interior cells land on base_addr.
   assign w_border = r_pad & ((r_row == '0) | (r_row == r_last_row) |
                              (r_col == '0) | (r_col == r_last_col));
   assign w_first_row_base = i_pad ? (i_base_addr - i_row_stride - ADDR_W'(1)) : i_base_addr;
   assign w_last_col = i_pad ? ({1'b0, i_width} + POS_W'(1))  : ({1'b0, i_width} - POS_W'(1));
   assign w_last_row = i_pad ? ({1'b0, i_height} + POS_W'(1)) : ({1'b0, i_height} - POS_W'(1));
`else
   assign w_border         = 1'b0;
   assign w_first_row_base = i_base_addr;
   assign w_last_col       = {1'b0, i_width} - POS_W'(1);
   assign w_last_row       = {1'b0, i_height} - POS_W'(1);
`endif

   assign w_zero_size = (i_width == '0) || (i_height == '0);
   assign w_pop       = o_out_valid & i_out_ready;

   // Credit check: in-flight word plus buffered words, less any word leaving this cycle.
   assign w_used  = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
   assign w_limit = (CNT_W + 1)'(FIFO_DEPTH) + {{CNT_W{1'b0}}, w_pop};
   assign w_issue = (r_state == StRun) && (w_used < w_limit);
   assign w_read  = w_issue & ~w_border;

   assign w_addr          = r_row_base + ADDR_W'(r_col);
   assign o_mem_read_addr = w_read ? w_addr : r_last_addr;

   assign w_tag.eol = (r_col == r_last_col);
   assign w_tag.eof = (r_col == r_last_col) && (r_row == r_last_row);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= StIdle;
         r_row_base      <= '0;
         r_stride        <= '0;
         r_last_addr     <= '0;
         r_col           <= '0;
         r_row           <= '0;
         r_last_col      <= '0;
         r_last_row      <= '0;
         r_inflight      <= 1'b0;
         r_inflight_zero <= 1'b0;
         r_inflight_tag  <= '0;
         r_done          <= 1'b0;
      end else begin
         r_done          <= 1'b0;
         r_inflight      <= w_issue;
         r_inflight_zero <= w_border;
         r_inflight_tag  <= w_tag;
         if (w_read) r_last_addr <= w_addr;
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  if (w_zero_size) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state    <= StRun;
                     r_row_base <= w_first_row_base;
                     r_stride   <= i_row_stride;
                     r_col      <= '0;
                     r_row      <= '0;
                     r_last_col <= w_last_col;
                     r_last_row <= w_last_row;
                  end
               end
            end
            StRun: begin
               if (w_issue) begin
                  if (w_tag.eof) begin
                     r_state <= StDrain;
                  end else if (w_tag.eol) begin
                     r_col      <= '0;
                     r_row      <= r_row + POS_W'(1);
                     r_row_base <= r_row_base + r_stride;
                  end else begin
                     r_col <= r_col + POS_W'(1);
                  end
               end
            end
            StDrain: begin
               if (w_pop && w_head_tag.eof) begin
                  r_state <= StIdle;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign w_push_data = r_inflight_zero ? '0 : i_mem_read_data;

   mem_stream_reader_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_inflight),
      .i_data  (w_push_data),
      .i_tag   (r_inflight_tag),
      .i_pop   (w_pop),
      .o_data  (o_out_data),
      .o_tag   (w_head_tag),
      .o_empty (w_fifo_empty),
      .o_count (w_count)
   );

   assign o_out_valid = ~w_fifo_empty;
   assign o_out_eol   = w_head_tag.eol;
   assign o_out_eof   = w_head_tag.eof;
   assign o_busy      = (r_state != StIdle);
   assign o_done      = r_done;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader: cycle table, corner sequences, randomized regions.
module tb_mem_stream_reader;

   localparam int unsigned AW    = 16;
   localparam int unsigned DW    = 18;
   localparam int unsigned DIMW  = 10;
   localparam int unsigned DEPTH = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            i_start;
   logic [AW-1:0]   i_base_addr;
   logic [AW-1:0]   i_row_stride;
   logic [DIMW-1:0] i_width;
   logic [DIMW-1:0] i_height;
   logic            i_pad;
   logic            o_busy;
   logic            o_done;
   logic [AW-1:0]   o_mem_read_addr;
   logic [DW-1:0]   mem_rd;
   logic [DW-1:0]   o_out_data;
   logic            o_out_valid;
   logic            i_out_ready;
   logic            o_out_eol;
   logic            o_out_eof;

   typedef struct {
      logic [DW-1:0] data;
      logic          eol;
      logic          eof;
   } word_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic          valid;
      logic [DW-1:0] data;
      logic          eol;
      logic          eof;
      logic          busy;
      logic          done;
   } vec_t;

   int      checks = 0;
   int      errors = 0;
   word_t   exp_q[$];
   logic [AW-1:0] exp_addr[$];
   vec_t    tbl[10];

   always #5 clk = ~clk;

   mem_stream_reader #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .DIM_W      (DIMW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_start         (i_start),
      .i_base_addr     (i_base_addr),
      .i_row_stride    (i_row_stride),
      .i_width         (i_width),
      .i_height        (i_height),
`ifdef MEM_STREAM_READER_PAD_EN
      .i_pad           (i_pad),
`endif
      .o_busy          (o_busy),
      .o_done          (o_done),
      .o_mem_read_addr (o_mem_read_addr),
      .i_mem_read_data (mem_rd),
      .o_out_data      (o_out_data),
      .o_out_valid     (o_out_valid),
      .i_out_ready     (i_out_ready),
      .o_out_eol       (o_out_eol),
      .o_out_eof       (o_out_eof)
   );

   // Distinct word per address, so a wrong address shows up as wrong data.
   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      logic [AW-1:0] h;
      h = a * 16'd40503;
      return {a[1:0] ^ 2'b11, h};
   endfunction

   always @(posedge clk) mem_rd <= mem_word(o_mem_read_addr);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic build_model(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                              input int w, input int h, input bit pad);
      int ww;
      int hh;
      word_t wd;
      logic [AW-1:0] a;
      exp_q.delete();
      exp_addr.delete();
      ww = pad ? w + 2 : w;
      hh = pad ? h + 2 : h;
      for (int r = 0; r < hh; r++) begin
         for (int c = 0; c < ww; c++) begin
            if (pad && (r == 0 || r == hh - 1 || c == 0 || c == ww - 1)) begin
               wd.data = '0;
            end else begin
               a = base + AW'(pad ? r - 1 : r) * stride + AW'(pad ? c - 1 : c);
               wd.data = mem_word(a);
               exp_addr.push_back(a);
            end
            wd.eol = (c == ww - 1);
            wd.eof = (c == ww - 1) && (r == hh - 1);
            exp_q.push_back(wd);
         end
      end
   endtask

   // mode 0: ready always high; 1: random ready and stray starts; 2: 5-cycle stall at first valid
   task automatic run_region(input string name, input logic [AW-1:0] base,
                             input logic [AW-1:0] stride, input int w, input int h,
                             input bit pad, input int mode);
      word_t held;
      bit    held_v     = 0;
      bit    done_next  = 0;
      bit    finished   = 0;
      bit    stalling   = 0;
      int    stall_left = 5;
      int    budget;
      build_model(base, stride, w, h, pad);
      budget = 100 + 20 * exp_q.size();
      @(posedge clk); #1;
      i_start = 1'b1; i_base_addr = base; i_row_stride = stride;
      i_width = DIMW'(w); i_height = DIMW'(h); i_pad = pad;
      i_out_ready = (mode != 2);
      @(posedge clk); #1;
      i_start = 1'b0;
      for (int cyc = 0; cyc < budget && !finished; cyc++) begin
         if (mode == 1) begin
            i_out_ready  = ($urandom_range(0, 9) < 7);
            i_start      = done_next ? 1'b0 : 1'($urandom_range(0, 1));
            i_width      = DIMW'($urandom);
            i_base_addr  = AW'($urandom);
            i_row_stride = AW'($urandom);
            i_pad        = 1'($urandom);
         end else if (mode == 2) begin
            if (o_out_valid && stall_left > 0) stalling = 1;
            i_out_ready = !(stalling && stall_left > 0);
         end else begin
            i_out_ready = 1'b1;
         end
         @(negedge clk);
         if (done_next) begin
            check({name, " done"}, o_done, 1'b1);
            check({name, " busy_end"}, o_busy, 1'b0);
            check({name, " valid_end"}, o_out_valid, 1'b0);
            finished = 1;
         end else begin
            check({name, " done_low"}, o_done, 1'b0);
            check({name, " busy"}, o_busy, 1'b1);
            if (held_v) begin
               check({name, " hold"}, {o_out_valid, o_out_data, o_out_eol, o_out_eof},
                     {1'b1, held.data, held.eol, held.eof});
            end
            held_v = 0;
            if (o_out_valid) begin
               if (exp_q.size() == 0) begin
                  check({name, " extra_word"}, o_out_data, 64'hDEAD_BEEF_0000);
               end else if (i_out_ready) begin
                  check({name, " word"}, {o_out_data, o_out_eol, o_out_eof},
                        {exp_q[0].data, exp_q[0].eol, exp_q[0].eof});
                  done_next = exp_q[0].eof;
                  void'(exp_q.pop_front());
               end else begin
                  held.data = o_out_data; held.eol = o_out_eol; held.eof = o_out_eof;
                  held_v = 1;
               end
            end
            if (stalling && stall_left > 0) begin
               stall_left--;
               if (stall_left == 0 && exp_addr.size() > DEPTH) begin
                  check({name, " stall_addr"}, o_mem_read_addr, exp_addr[DEPTH-1]);
               end
            end
         end
         @(posedge clk); #1;
      end
      i_start = 1'b0;
      if (!finished) check({name, " timeout_words_left"}, exp_q.size(), 0);
   endtask

   task automatic run_table(input string name);
      @(posedge clk); #1;
      i_start = 1'b1; i_base_addr = 16'h0100; i_row_stride = 16'd8;
      i_width = 10'd3; i_height = 10'd2; i_pad = 1'b0; i_out_ready = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check($sformatf("%s row%0d", name, k),
               {o_mem_read_addr, o_out_valid, o_out_valid ? o_out_data : 18'h0,
                o_out_valid & o_out_eol, o_out_valid & o_out_eof, o_busy, o_done},
               {tbl[k].addr, tbl[k].valid, tbl[k].data, tbl[k].eol, tbl[k].eof,
                tbl[k].busy, tbl[k].done});
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int acc;
      // {addr, valid, data, eol, eof, busy, done} per cycle after the accepted start
      tbl[0] = '{16'h0100, 1'b0, 18'h0,              1'b0, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{16'h0101, 1'b0, 18'h0,              1'b0, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{16'h0102, 1'b1, mem_word(16'h0100), 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{16'h0108, 1'b1, mem_word(16'h0101), 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{16'h0109, 1'b1, mem_word(16'h0102), 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{16'h010A, 1'b1, mem_word(16'h0108), 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{16'h010A, 1'b1, mem_word(16'h0109), 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{16'h010A, 1'b1, mem_word(16'h010A), 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[8] = '{16'h010A, 1'b0, 18'h0,              1'b0, 1'b0, 1'b0, 1'b1};
      tbl[9] = '{16'h010A, 1'b0, 18'h0,              1'b0, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_row_stride = '0;
      i_width = '0; i_height = '0; i_pad = 1'b0; i_out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {o_busy, o_done, o_out_valid, o_mem_read_addr}, 19'h0);
      rst_n = 1'b1;

      run_table("basic");

      // Zero-size start: done next cycle, never busy, no data.
      @(posedge clk); #1;
      i_start = 1'b1; i_width = 10'd0; i_height = 10'd4; i_out_ready = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      @(negedge clk);
      check("zero done", {o_done, o_busy, o_out_valid}, 3'b100);
      @(posedge clk); #1;
      @(negedge clk);
      check("zero after", {o_done, o_busy, o_out_valid}, 3'b000);

      run_region("bp", 16'h0100, 16'd8, 3, 2, 1'b0, 2);
      run_region("wrap", 16'hFFFE, 16'd1, 4, 1, 1'b0, 0);

      // Reset mid-run after three accepted words of a 4x4 region.
      @(posedge clk); #1;
      i_start = 1'b1; i_base_addr = 16'h0200; i_row_stride = 16'h0010;
      i_width = 10'd4; i_height = 10'd4; i_out_ready = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      acc = 0;
      for (int cyc = 0; cyc < 50 && acc < 3; cyc++) begin
         @(negedge clk);
         if (o_out_valid && i_out_ready) acc++;
         @(posedge clk); #1;
      end
      check("midrst accepted", acc, 3);
      rst_n = 1'b0;
      #1;
      check("midrst outputs", {o_busy, o_done, o_out_valid, o_mem_read_addr}, 19'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("midrst quiet", {o_busy, o_done, o_out_valid}, 3'b000);
         @(posedge clk); #1;
      end
      run_table("after_rst");

`ifdef MEM_STREAM_READER_PAD_EN
      run_region("pad", 16'h0010, 16'h0020, 2, 1, 1'b1, 0);
      run_region("pad_bp", 16'h0400, 16'h0040, 3, 2, 1'b1, 1);
`endif

      for (int n = 0; n < 14; n++) begin
         bit pad_r;
         pad_r = 1'b0;
`ifdef MEM_STREAM_READER_PAD_EN
         pad_r = 1'($urandom);
`endif
         run_region($sformatf("rnd%0d", n), AW'($urandom), AW'($urandom),
                    $urandom_range(1, 5), $urandom_range(1, 4), pad_r, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
